// File: rtl/pktgen_sequencer_if.sv
// ---------------------------------------------------------------------------
// pktgen_sequencer_if
// Job-descriptor command channel into the packet-generator sequencer.
//   cmd_valid   : descriptor present (producer -> sequencer)
//   cmd_ready   : sequencer can accept a descriptor this cycle
//   cmd_length  : bytes per packet
//   cmd_count   : packets in the job
//   cmd_idle    : idle cycles between packets
//   cmd_initial : first data word
// master = descriptor producer, slave = sequencer.
// ---------------------------------------------------------------------------
interface pktgen_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_length;
  logic [15:0] cmd_count;
  logic [15:0] cmd_idle;
  logic [15:0] cmd_initial;

  modport master (
    output cmd_valid, cmd_length, cmd_count, cmd_idle, cmd_initial,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_length, cmd_count, cmd_idle, cmd_initial,
    output cmd_ready
  );
endinterface

// File: rtl/pktgen_sequencer.sv
// ---------------------------------------------------------------------------
// pktgen_sequencer
// Job scheduler in front of the AXI-Stream packet generator. Jobs are queued
// through the command interface; on go they are issued one after another to
// the generator, with a programmable gap between jobs. The generator
// configuration is held stable from pg_start until pg_busy falls.
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   cmd (slave)           : job descriptor valid/ready channel
//   go                    : pulse, start draining the queue (ignored if running)
//   abort                 : pulse, flush queue and stop after current job
//   job_gap               : idle clocks between jobs, sampled at job end
//   pg_packet_length,
//   pg_packet_count,
//   pg_idle_cycles,
//   pg_initial_value      : generator configuration
//   pg_start              : one-cycle start pulse to the generator
//   pg_busy               : generator busy
//   running               : sequencer not idle
//   done_pulse            : high in the first idle cycle after a run
//   jobs_done             : completed + skipped jobs (wrapping)
//   queue_level           : number of queued jobs
// ---------------------------------------------------------------------------
module pktgen_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  pktgen_sequencer_if.slave            cmd,
  input  logic                         go,
  input  logic                         abort,
  input  logic [15:0]                  job_gap,
  output logic [15:0]                  pg_packet_length,
  output logic [15:0]                  pg_packet_count,
  output logic [15:0]                  pg_idle_cycles,
  output logic [15:0]                  pg_initial_value,
  output logic                         pg_start,
  input  logic                         pg_busy,
  output logic                         running,
  output logic                         done_pulse,
  output logic [15:0]                  jobs_done,
  output logic [$clog2(DEPTH+1)-1:0]   queue_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [15:0] length;
    logic [15:0] count;
    logic [15:0] idle;
    logic [15:0] init;
  } job_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  state_t          state, state_next;
  logic            abort_pending, abort_pending_next;
  logic [15:0]     gap_cnt;

  job_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_next;
  job_t            head;
  logic            full, push, pop, skip;

  logic            decide;
  logic            gap_load;
  logic            load_pg;
  logic            jobs_inc;

  // -------------------------------------------------------------------------
  // Job queue
  // -------------------------------------------------------------------------
  assign full          = (queue_level == LW'(DEPTH));
  // Uses the registered level, so a pop at full does not open the port in
  // the same cycle.
  assign cmd.cmd_ready = !full && !abort;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign pop           = (state == S_LOAD);
  assign head          = mem[rd_ptr];
  assign skip          = (head.length == 16'd0) || (head.count == 16'd0);

  // Level as it will be after this edge; abort flushes everything, and the
  // port is closed during abort so no push can race the flush.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    level_next = queue_level;
    if (abort) begin
      level_next = '0;
    end else if (push && !pop) begin
      level_next = queue_level + LW'(1);
    end else if (!push && pop) begin
      level_next = queue_level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_level <= '0;
    end else begin
      queue_level <= level_next;
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and level
  // define which entries are meaningful, so clearing the data buys nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{length: cmd.cmd_length, count: cmd.cmd_count,
                       idle: cmd.cmd_idle, init: cmd.cmd_initial};
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM: next state and strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    decide     = 1'b0;
    gap_load   = 1'b0;
    load_pg    = 1'b0;
    jobs_inc   = 1'b0;

    unique case (state)
      S_IDLE: begin
        // abort in IDLE only flushes; it wins over a simultaneous go.
        if (!abort && go && (queue_level != '0)) state_next = S_LOAD;
      end
      S_LOAD: begin
        if (skip) begin
          jobs_inc = 1'b1;
          decide   = 1'b1;
        end else begin
          load_pg    = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        // pg_busy is not looked at here; the generator raises it next cycle.
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (!pg_busy) begin
          jobs_inc = 1'b1;
          decide   = 1'b1;
        end
      end
      S_GAP: begin
        if (abort)                  state_next = S_IDLE;
        else if (gap_cnt == 16'd0)  state_next = S_LOAD;
      end
      default: state_next = S_IDLE;
    endcase

    // End-of-job branch. level_next already reflects this cycle's pop and any
    // abort flush, so an abort arriving right now also ends the run.
    if (decide) begin
      if (abort_pending || (level_next == '0)) begin
        state_next = S_IDLE;
      end else if (job_gap == 16'd0) begin
        state_next = S_LOAD;
      end else begin
        gap_load   = 1'b1;
        state_next = S_GAP;
      end
    end
  end

  // Pending abort lives until the run returns to IDLE.
  always_comb begin
    abort_pending_next = abort_pending;
    if (state_next == S_IDLE)       abort_pending_next = 1'b0;
    else if (abort)                 abort_pending_next = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM: registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      abort_pending <= 1'b0;
      gap_cnt       <= '0;
      done_pulse    <= 1'b0;
      jobs_done     <= '0;
    end else begin
      state         <= state_next;
      abort_pending <= abort_pending_next;
      done_pulse    <= (state != S_IDLE) && (state_next == S_IDLE);
      if (jobs_inc) jobs_done <= jobs_done + 16'd1;
      if (gap_load) begin
        gap_cnt <= job_gap - 16'd1;
      end else if ((state == S_GAP) && (gap_cnt != 16'd0)) begin
        gap_cnt <= gap_cnt - 16'd1;
      end
    end
  end

  // Generator configuration only moves on a non-skipped LOAD edge, which
  // keeps it stable through START and the whole busy window.
  always_ff @(posedge clk) begin
    if (reset) begin
      pg_packet_length <= '0;
      pg_packet_count  <= '0;
      pg_idle_cycles   <= '0;
      pg_initial_value <= '0;
    end else if (load_pg) begin
      pg_packet_length <= head.length;
      pg_packet_count  <= head.count;
      pg_idle_cycles   <= head.idle;
      pg_initial_value <= head.init;
    end
  end

  assign pg_start = (state == S_START);
  assign running  = (state != S_IDLE);

endmodule

// File: tb/tb_pktgen_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pktgen_sequencer
// Directed bench for pktgen_sequencer. A small generator model drives
// pg_busy; a scoreboard of expected configurations is filled as jobs are
// pushed and drained on every pg_start.
// ---------------------------------------------------------------------------
module tb_pktgen_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        abort;
  logic [15:0] job_gap;
  logic [15:0] pg_packet_length, pg_packet_count, pg_idle_cycles, pg_initial_value;
  logic        pg_start;
  logic        pg_busy = 1'b0;
  logic        running;
  logic        done_pulse;
  logic [15:0] jobs_done;
  logic [2:0]  queue_level;

  pktgen_sequencer_if cmd_if ();

  pktgen_sequencer #(.DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd              (cmd_if),
    .go               (go),
    .abort            (abort),
    .job_gap          (job_gap),
    .pg_packet_length (pg_packet_length),
    .pg_packet_count  (pg_packet_count),
    .pg_idle_cycles   (pg_idle_cycles),
    .pg_initial_value (pg_initial_value),
    .pg_start         (pg_start),
    .pg_busy          (pg_busy),
    .running          (running),
    .done_pulse       (done_pulse),
    .jobs_done        (jobs_done),
    .queue_level      (queue_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [63:0] sb [$];
  logic [63:0] cur_cfg = '0;
  int          start_cycs [$];
  int          fall_cycs  [$];
  int          done_cnt  = 0;
  int          busy_len  = 4;
  int          busy_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cfg_now();
    return {pg_packet_length, pg_packet_count, pg_idle_cycles, pg_initial_value};
  endfunction

  // Generator model: busy from the cycle after pg_start for busy_len cycles.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
      pg_busy  = 1'b0;
    end else if (pg_start) begin
      busy_cnt = busy_len;
      pg_busy  = 1'b1;
    end else if (busy_cnt > 1) begin
      busy_cnt--;
    end else if (pg_busy) begin
      busy_cnt = 0;
      pg_busy  = 1'b0;
      fall_cycs.push_back(cyc);
    end
  end

  // Monitor: scoreboard pop on pg_start, configuration stability while busy.
  always @(negedge clk) begin
    if (!reset) begin
      if (pg_start) begin
        start_cycs.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_pg_start", 64'(pg_start), 64'(0));
        end else begin
          cur_cfg = sb.pop_front();
          check("pg_cfg_at_start", cfg_now(), cur_cfg);
        end
      end else if (pg_busy) begin
        check("pg_cfg_stable_busy", cfg_now(), cur_cfg);
      end
      if (done_pulse) begin
        done_cnt++;
        check("done_pulse_in_idle", 64'(running), 64'(0));
      end
    end
  end

  task automatic push_job(input logic [15:0] len, input logic [15:0] cnt,
                          input logic [15:0] idl, input logic [15:0] init);
    int n = 0;
    @(negedge clk);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_length  = len;
    cmd_if.cmd_count   = cnt;
    cmd_if.cmd_idle    = idl;
    cmd_if.cmd_initial = init;
    #1;
    while (!cmd_if.cmd_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("push_accepted", 64'(cmd_if.cmd_ready), 64'(1));
    if (len != 0 && cnt != 0) sb.push_back({len, cnt, idl, init});
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic pulse_go(output int go_cyc);
    @(negedge clk); #1;
    go     = 1'b1;
    go_cyc = cyc;
    @(negedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (running && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check("run_finished", 64'(running), 64'(0));
    @(negedge clk); #1;
  endtask

  task automatic wait_starts(input int want);
    int n = 0;
    while (start_cycs.size() < want && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check("start_seen", 64'(start_cycs.size()), 64'(want));
  endtask

  task automatic clear_run();
    start_cycs.delete();
    fall_cycs.delete();
    done_cnt = 0;
  endtask

  int go_cyc;
  int t0;
  int s;
  int n;
  int exp_jobs;

  initial begin
    reset            = 1'b1;
    go               = 1'b0;
    abort            = 1'b0;
    job_gap          = 16'd0;
    cmd_if.cmd_valid   = 1'b0;
    cmd_if.cmd_length  = '0;
    cmd_if.cmd_count   = '0;
    cmd_if.cmd_idle    = '0;
    cmd_if.cmd_initial = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;

    // Reset state
    check("rst_pg_start",    64'(pg_start),    64'(0));
    check("rst_running",     64'(running),     64'(0));
    check("rst_done_pulse",  64'(done_pulse),  64'(0));
    check("rst_jobs_done",   64'(jobs_done),   64'(0));
    check("rst_queue_level", 64'(queue_level), 64'(0));
    check("rst_cmd_ready",   64'(cmd_if.cmd_ready), 64'(1));
    check("rst_pg_cfg",      cfg_now(),        64'(0));
    exp_jobs = 0;

    // Two jobs, zero gap
    clear_run();
    busy_len = 4;
    job_gap  = 16'd0;
    push_job(16'd64, 16'd2, 16'd3, 16'h10);
    push_job(16'd100, 16'd1, 16'd0, 16'h20);
    @(negedge clk); #1;
    check("t1_level_2", 64'(queue_level), 64'(2));
    pulse_go(go_cyc);
    wait_idle(200);
    exp_jobs += 2;
    check("t1_start_count", 64'(start_cycs.size()), 64'(2));
    if (start_cycs.size() == 2 && fall_cycs.size() >= 1) begin
      check("t1_go_latency",  64'(start_cycs[0] - go_cyc),       64'(2));
      check("t1_b2b_latency", 64'(start_cycs[1] - fall_cycs[0]), 64'(2));
    end
    check("t1_jobs_done", 64'(jobs_done), 64'(exp_jobs));
    check("t1_done_cnt",  64'(done_cnt),  64'(1));
    check("t1_sb_empty",  64'(sb.size()), 64'(0));

    // Gap of 5
    clear_run();
    job_gap = 16'd5;
    push_job(16'd64, 16'd2, 16'd3, 16'h10);
    push_job(16'd100, 16'd1, 16'd0, 16'h20);
    pulse_go(go_cyc);
    wait_idle(200);
    exp_jobs += 2;
    check("t2_start_count", 64'(start_cycs.size()), 64'(2));
    if (start_cycs.size() == 2 && fall_cycs.size() >= 1)
      check("t2_gap_latency", 64'(start_cycs[1] - fall_cycs[0]), 64'(7));
    check("t2_jobs_done", 64'(jobs_done), 64'(exp_jobs));
    check("t2_done_cnt",  64'(done_cnt),  64'(1));

    // Full queue
    clear_run();
    job_gap = 16'd0;
    for (int i = 0; i < 4; i++) push_job(16'd8, 16'd1, 16'd0, 16'(16'h31 + i));
    @(negedge clk); #1;
    check("t3_level_full", 64'(queue_level),       64'(4));
    check("t3_ready_full", 64'(cmd_if.cmd_ready),  64'(0));
    @(negedge clk); #1;
    go                 = 1'b1;
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_length  = 16'd8;
    cmd_if.cmd_count   = 16'd1;
    cmd_if.cmd_idle    = 16'd0;
    cmd_if.cmd_initial = 16'h35;
    sb.push_back({16'd8, 16'd1, 16'd0, 16'h35});
    t0 = cyc;
    @(negedge clk); #1;
    go = 1'b0;
    n  = 0;
    while (!cmd_if.cmd_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("t3_ready_after_load", 64'(cyc - t0), 64'(2));
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    wait_idle(300);
    exp_jobs += 5;
    check("t3_start_count", 64'(start_cycs.size()), 64'(5));
    check("t3_jobs_done",   64'(jobs_done),         64'(exp_jobs));
    check("t3_sb_empty",    64'(sb.size()),         64'(0));

    // Skipped jobs
    clear_run();
    push_job(16'd0, 16'd3, 16'd0, 16'd0);
    push_job(16'd64, 16'd0, 16'd0, 16'd0);
    push_job(16'd64, 16'd1, 16'd0, 16'd7);
    pulse_go(go_cyc);
    wait_idle(200);
    exp_jobs += 3;
    check("t4_start_count", 64'(start_cycs.size()), 64'(1));
    check("t4_initial",     64'(pg_initial_value),  64'(7));
    check("t4_jobs_done",   64'(jobs_done),         64'(exp_jobs));
    check("t4_done_cnt",    64'(done_cnt),          64'(1));

    // Abort during job 1 of 3
    clear_run();
    busy_len = 8;
    for (int i = 0; i < 3; i++) push_job(16'd16, 16'd1, 16'd0, 16'(16'h41 + i));
    pulse_go(go_cyc);
    wait_starts(1);
    @(negedge clk); #1;
    abort = 1'b1;
    #1;
    check("t5_ready_in_abort", 64'(cmd_if.cmd_ready), 64'(0));
    @(negedge clk); #1;
    abort = 1'b0;
    check("t5_level_flushed", 64'(queue_level), 64'(0));
    check("t5_still_running", 64'(running),     64'(1));
    wait_idle(200);
    exp_jobs += 1;
    check("t5_start_count", 64'(start_cycs.size()), 64'(1));
    check("t5_jobs_done",   64'(jobs_done),         64'(exp_jobs));
    check("t5_done_cnt",    64'(done_cnt),          64'(1));
    check("t5_level_end",   64'(queue_level),       64'(0));
    check("t5_sb_left",     64'(sb.size()),         64'(2));
    sb.delete();

    // Abort in GAP
    clear_run();
    busy_len = 4;
    job_gap  = 16'd10;
    push_job(16'd16, 16'd1, 16'd0, 16'h51);
    push_job(16'd16, 16'd1, 16'd0, 16'h52);
    pulse_go(go_cyc);
    wait_starts(1);
    s = cyc;
    repeat (7) @(negedge clk);
    #1;
    check("t6_running_in_gap", 64'(running), 64'(1));
    check("t6_busy_low_in_gap", 64'(pg_busy), 64'(0));
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    check("t6_idle_next_cycle", 64'(running),    64'(0));
    check("t6_done_pulse",      64'(done_pulse), 64'(1));
    check("t6_cycle",           64'(cyc - s),    64'(8));
    repeat (3) @(negedge clk);
    #1;
    exp_jobs += 1;
    check("t6_start_count", 64'(start_cycs.size()), 64'(1));
    check("t6_jobs_done",   64'(jobs_done),         64'(exp_jobs));
    check("t6_done_cnt",    64'(done_cnt),          64'(1));
    sb.delete();

    // Reset mid-WAIT
    clear_run();
    busy_len = 10;
    job_gap  = 16'd0;
    for (int i = 0; i < 3; i++) push_job(16'd32, 16'd1, 16'd0, 16'(16'h61 + i));
    pulse_go(go_cyc);
    wait_starts(1);
    @(negedge clk); #1;
    check("t7_level_in_wait", 64'(queue_level), 64'(2));
    check("t7_busy_in_wait",  64'(pg_busy),     64'(1));
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    check("t7_pg_start",    64'(pg_start),          64'(0));
    check("t7_running",     64'(running),           64'(0));
    check("t7_done_pulse",  64'(done_pulse),        64'(0));
    check("t7_jobs_done",   64'(jobs_done),         64'(0));
    check("t7_queue_level", 64'(queue_level),       64'(0));
    check("t7_cmd_ready",   64'(cmd_if.cmd_ready),  64'(1));
    check("t7_pg_cfg",      cfg_now(),              64'(0));
    sb.delete();
    pulse_go(go_cyc);
    repeat (5) @(negedge clk);
    #1;
    check("t7_go_ignored",  64'(running),           64'(0));
    check("t7_no_start",    64'(start_cycs.size()), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
